// File: rtl/sin_osc_iq_ctrl.sv
// sin_osc_iq_ctrl: sequencer for the I/Q sine oscillator with a 1-deep I/Q output.
// Optional: define SIN_OSC_OVERRUN_CNT_EN to count dropped sample ticks.
module sin_osc_iq_ctrl #(
  parameter int DW    = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             sample_tick,
  output logic             osc_rst,
  output logic             osc_next,
  input  logic [DW-1:0]    osc_i,
  input  logic [DW-1:0]    osc_q,
  output logic [DW-1:0]    iq_i,
  output logic [DW-1:0]    iq_q,
  output logic             iq_valid,
  input  logic             iq_ready,
  output logic             busy,
  output logic             done,
  output logic [15:0]      overrun_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_STEP,
    S_WAIT
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             prime_last;
  logic             stop_pend;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] n_lat;
  logic             go;
  logic             cap;
  logic             fin;
  logic             can_take;

  assign cnt_inc  = cnt + 1'b1;
  assign can_take = !iq_valid || iq_ready;
  assign osc_next = (state == S_STEP);
  assign busy     = (state != S_IDLE);

  // Next-state decode and burst control strobes
  always_comb begin
    state_nx = state;
    go       = 1'b0;
    cap      = 1'b0;
    fin      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && !stop) begin
          go       = 1'b1;
          state_nx = S_PRIME;
        end
      end
      S_PRIME: begin
        if (prime_last) state_nx = S_RUN;
      end
      S_RUN: begin
        if (stop || stop_pend) begin
          fin      = 1'b1;
          state_nx = S_IDLE;
        end else if (sample_tick && can_take) begin
          state_nx = S_STEP;
        end
      end
      S_STEP: state_nx = S_WAIT;
      S_WAIT: begin
        cap = 1'b1;
        if (stop || stop_pend ||
            (n_lat != '0 && cnt_inc == n_lat)) begin
          fin      = 1'b1;
          state_nx = S_IDLE;
        end else begin
          state_nx = S_RUN;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State register, phase prime, burst counter and pending stop
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      prime_last <= 1'b0;
      stop_pend  <= 1'b0;
      cnt        <= '0;
      n_lat      <= '0;
      osc_rst    <= 1'b1;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      osc_rst    <= (state_nx == S_PRIME);
      done       <= fin;
      prime_last <= (state == S_PRIME) && !prime_last;
      if (go) begin
        n_lat <= n_samples;
        cnt   <= '0;
      end else if (cap) begin
        cnt <= cnt_inc;
      end
      if (fin || go) begin
        stop_pend <= 1'b0;
      end else if (stop && (state == S_PRIME ||
                            state == S_STEP ||
                            state == S_WAIT)) begin
        stop_pend <= 1'b1;
      end
    end
  end

  // Output holding register; a fresh capture beats a same-edge handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      iq_i     <= '0;
      iq_q     <= '0;
      iq_valid <= 1'b0;
    end else if (cap) begin
      iq_i     <= osc_i;
      iq_q     <= osc_q;
      iq_valid <= 1'b1;
    end else if (iq_valid && iq_ready) begin
      iq_valid <= 1'b0;
    end
  end

`ifdef SIN_OSC_OVERRUN_CNT_EN
  logic        drop;
  logic [15:0] ovr;

  assign drop = sample_tick &&
                (state == S_PRIME || state == S_STEP ||
                 state == S_WAIT ||
                 (state == S_RUN && !can_take));
  assign overrun_cnt = ovr;

  // Saturating dropped-tick counter, cleared when a burst starts
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr <= '0;
    end else if (go) begin
      ovr <= '0;
    end else if (drop && ovr != 16'hFFFF) begin
      ovr <= ovr + 16'd1;
    end
  end
`else
  assign overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_sin_osc_iq_ctrl.sv
// tb_sin_osc_iq_ctrl: self-checking bench for sin_osc_iq_ctrl
// with a behavioural table oscillator and a pair scoreboard.
module tb_sin_osc_iq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [15:0] n_samples;
  logic        sample_tick;
  logic        osc_rst;
  logic        osc_next;
  logic [15:0] osc_i = '0;
  logic [15:0] osc_q = '0;
  logic [15:0] iq_i;
  logic [15:0] iq_q;
  logic        iq_valid;
  logic        iq_ready;
  logic        busy;
  logic        done;
  logic [15:0] overrun_cnt;

  int passes = 0;
  int checks = 0;

  int cos_t [8] = '{32767, 23170, 0, -23170, -32767, -23170, 0, 23170};
  int sin_t [8] = '{0, 23170, 32767, 23170, 0, -23170, -32767, -23170};

`ifdef SIN_OSC_OVERRUN_CNT_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  sin_osc_iq_ctrl #(.DW(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .n_samples(n_samples), .sample_tick(sample_tick),
    .osc_rst(osc_rst), .osc_next(osc_next),
    .osc_i(osc_i), .osc_q(osc_q),
    .iq_i(iq_i), .iq_q(iq_q),
    .iq_valid(iq_valid), .iq_ready(iq_ready),
    .busy(busy), .done(done), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  // Oscillator model: read-then-advance on negedge, LUT register on posedge
  logic [2:0] oidx = '0;
  logic [2:0] ord  = '0;
  always @(negedge clk) begin
    if (osc_rst) oidx <= '0;
    else if (osc_next) begin
      ord  <= oidx;
      oidx <= oidx + 3'd1;
    end
  end
  always @(posedge clk) begin
    osc_i <= 16'(cos_t[ord]);
    osc_q <= 16'(sin_t[ord]);
  end

  // Monitor: pulse counters and accepted-pair scoreboard queue
  int          n_next_tot = 0;
  int          n_done_tot = 0;
  logic [31:0] rxq [$];
  always @(negedge clk) begin
    if (osc_next) n_next_tot <= n_next_tot + 1;
    if (done) n_done_tot <= n_done_tot + 1;
    if (iq_valid && iq_ready && !rst) rxq.push_back({iq_i, iq_q});
  end

  function automatic logic [31:0] exp_pair(input int k);
    return {16'(cos_t[k % 8]), 16'(sin_t[k % 8])};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [15:0] n);
    n_samples = n;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic send_tick(input int gap);
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
    step(gap - 1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(3);
    @(negedge clk);
    checks++;
    if ({osc_rst, osc_next, iq_valid, busy, done} !== 5'b10000) begin
      $display("FAIL reset_ctl: got %b want 10000",
               {osc_rst, osc_next, iq_valid, busy, done});
    end else passes++;
    checks++;
    if ({iq_i, iq_q, overrun_cnt} !== 48'h0) begin
      $display("FAIL reset_data: got %h want 0",
               {iq_i, iq_q, overrun_cnt});
    end else passes++;
    rst = 1'b0;
    step(1);
    @(negedge clk);
    checks++;
    if ({osc_rst, busy} !== 2'b00) begin
      $display("FAIL reset_release: got %b want 00", {osc_rst, busy});
    end else passes++;
    step(1);
  endtask

  task automatic test_burst(input int n);
    int bn = n_next_tot;
    int bd = n_done_tot;
    int br = rxq.size();
    iq_ready = 1'b1;
    pulse_start(16'(n));
    step(3);
    for (int i = 0; i < n; i++) send_tick($urandom_range(3, 10));
    step(4);
    checks++;
    if (n_next_tot - bn !== n) begin
      $display("FAIL burst_pulses: got %0d want %0d", n_next_tot - bn, n);
    end else passes++;
    checks++;
    if (n_done_tot - bd !== 1 || busy !== 1'b0) begin
      $display("FAIL burst_done: got done=%0d busy=%b want 1 0",
               n_done_tot - bd, busy);
    end else passes++;
    checks++;
    if (rxq.size() - br !== n) begin
      $display("FAIL burst_pairs: got %0d want %0d", rxq.size() - br, n);
    end else passes++;
    for (int i = 0; i < n && br + i < rxq.size(); i++) begin
      checks++;
      if (rxq[br + i] !== exp_pair(i)) begin
        $display("FAIL burst_data[%0d]: got %h want %h",
                 i, rxq[br + i], exp_pair(i));
      end else passes++;
    end
    checks++;
    if (overrun_cnt !== 16'd0) begin
      $display("FAIL burst_ovr: got %0d want 0", overrun_cnt);
    end else passes++;
  endtask

  task automatic test_latency;
    iq_ready = 1'b1;
    pulse_start(16'd1);
    step(3);
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
    @(negedge clk);
    checks++;
    if ({osc_next, iq_valid} !== 2'b10) begin
      $display("FAIL lat_step: got %b want 10", {osc_next, iq_valid});
    end else passes++;
    @(negedge clk);
    checks++;
    if ({osc_next, iq_valid} !== 2'b00) begin
      $display("FAIL lat_wait: got %b want 00", {osc_next, iq_valid});
    end else passes++;
    @(negedge clk);
    checks++;
    if ({iq_valid, done, busy} !== 3'b110 ||
        {iq_i, iq_q} !== exp_pair(0)) begin
      $display("FAIL lat_cap: got v=%b d=%b b=%b %h want 110 %h",
               iq_valid, done, busy, {iq_i, iq_q}, exp_pair(0));
    end else passes++;
    step(2);
  endtask

  task automatic test_backpressure;
    int bn = n_next_tot;
    int bd = n_done_tot;
    int br = rxq.size();
    iq_ready = 1'b0;
    pulse_start(16'd0);
    step(3);
    repeat (6) send_tick(4);
    checks++;
    if (n_next_tot - bn !== 1) begin
      $display("FAIL bp_pulses: got %0d want 1", n_next_tot - bn);
    end else passes++;
    checks++;
    if ({iq_valid, busy} !== 2'b11 || {iq_i, iq_q} !== exp_pair(0) ||
        rxq.size() !== br) begin
      $display("FAIL bp_hold: got v=%b b=%b %h want 11 %h",
               iq_valid, busy, {iq_i, iq_q}, exp_pair(0));
    end else passes++;
    checks++;
    if (overrun_cnt !== (OVR_EN ? 16'd5 : 16'd0)) begin
      $display("FAIL bp_ovr: got %0d want %0d",
               overrun_cnt, OVR_EN ? 5 : 0);
    end else passes++;
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, iq_valid} !== 3'b011) begin
      $display("FAIL bp_stop: got %b want 011", {busy, done, iq_valid});
    end else passes++;
    iq_ready = 1'b1;
    step(2);
    checks++;
    if (iq_valid !== 1'b0 || rxq.size() - br !== 1 ||
        n_done_tot - bd !== 1) begin
      $display("FAIL bp_drain: got v=%b rx=%0d d=%0d want 0 1 1",
               iq_valid, rxq.size() - br, n_done_tot - bd);
    end else passes++;
    if (rxq.size() > br) begin
      checks++;
      if (rxq[br] !== exp_pair(0)) begin
        $display("FAIL bp_data: got %h want %h", rxq[br], exp_pair(0));
      end else passes++;
    end
  endtask

  task automatic test_stop_in_step;
    int bn = n_next_tot;
    int bd = n_done_tot;
    int br = rxq.size();
    iq_ready = 1'b1;
    pulse_start(16'd0);
    step(3);
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(3);
    checks++;
    if (n_next_tot - bn !== 1 || n_done_tot - bd !== 1 || busy !== 1'b0) begin
      $display("FAIL stop_step: got p=%0d d=%0d b=%b want 1 1 0",
               n_next_tot - bn, n_done_tot - bd, busy);
    end else passes++;
    checks++;
    if (rxq.size() - br !== 1 ||
        (rxq.size() > br && rxq[br] !== exp_pair(0))) begin
      $display("FAIL stop_step_data: got n=%0d want 1 pair %h",
               rxq.size() - br, exp_pair(0));
    end else passes++;
    checks++;
    if (overrun_cnt !== 16'd0) begin
      $display("FAIL stop_step_ovr: got %0d want 0", overrun_cnt);
    end else passes++;
  endtask

  task automatic test_start_stop;
    start = 1'b1;
    stop  = 1'b1;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, osc_rst} !== 2'b00) begin
      $display("FAIL start_stop: got %b want 00", {busy, osc_rst});
    end else passes++;
    step(2);
    checks++;
    if ({busy, osc_rst, osc_next} !== 3'b000) begin
      $display("FAIL start_stop_idle: got %b want 000",
               {busy, osc_rst, osc_next});
    end else passes++;
  endtask

  task automatic test_reset_in_wait;
    int bd = n_done_tot;
    int br = rxq.size();
    iq_ready = 1'b1;
    pulse_start(16'd0);
    step(3);
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
    @(negedge clk);
    checks++;
    if ({busy, iq_valid, done, osc_rst} !== 4'b0001 ||
        overrun_cnt !== 16'd0) begin
      $display("FAIL rst_wait: got %b ovr=%0d want 0001 0",
               {busy, iq_valid, done, osc_rst}, overrun_cnt);
    end else passes++;
    checks++;
    if (n_done_tot - bd !== 0 || rxq.size() - br !== 0) begin
      $display("FAIL rst_wait_abort: got d=%0d rx=%0d want 0 0",
               n_done_tot - bd, rxq.size() - br);
    end else passes++;
    rst = 1'b0;
    step(2);
    checks++;
    if ({busy, osc_rst} !== 2'b00) begin
      $display("FAIL rst_wait_rel: got %b want 00", {busy, osc_rst});
    end else passes++;
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    stop        = 1'b0;
    n_samples   = '0;
    sample_tick = 1'b0;
    iq_ready    = 1'b0;
    test_reset();
    test_burst(4);
    test_burst($urandom_range(1, 9));
    test_latency();
    test_backpressure();
    test_stop_in_step();
    test_start_stop();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
